fetch_stage_ctrl: RTL and testbench

//  Fetch side of the pipeline: the consumer of the hazard unit's PCWrite, IF_ID_Write and IF_Flush.
//  - Owns the PC register and the IF/ID pipeline register.
//  - Issues one-outstanding-request fetches over a valid/ready instruction-memory interface

---
 rtl/fetch_stage_ctrl.sv | 130 +++++++++++++
 tb/tb_fetch_stage_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage controller: owns the PC and the IF/ID register, and keeps at most one
// request outstanding on a variable-latency valid/ready instruction-memory port.
//
//   state  | meaning
//   S_REQ  | request for pc presented, waiting for imem_req_ready
//   S_WAIT | request accepted, waiting for the response
//   S_HOLD | response captured in buf_instr while the pipeline is stalled
//   S_DROP | in-flight response is stale after a flush, discard it on arrival
module fetch_stage_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCWrite,
    input  logic            IF_ID_Write,
    input  logic            IF_Flush,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] IF_ID_PC,
    output logic [31:0]     IF_ID_Instr,
    output logic            IF_ID_Valid
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [31:0]     buf_instr;

    logic            advance;
    logic            req_fire;
    logic            deliver;
    logic [31:0]     deliver_instr;
    logic [XLEN-1:0] pc_next;

    assign imem_req_valid = (state == S_REQ) && !reset;
    assign imem_req_addr  = pc;
    assign pc_out         = pc;

    assign advance  = PCWrite & IF_ID_Write;
    assign req_fire = imem_req_valid & imem_req_ready;
    assign pc_next  = pc + XLEN'(4);

    // An instruction reaches IF/ID only when the pipeline advances and no flush squashes it.
    always_comb begin
        deliver       = 1'b0;
        deliver_instr = buf_instr;
        if (!IF_Flush && advance) begin
            case (state)
                S_WAIT: begin
                    deliver       = imem_resp_valid;
                    deliver_instr = imem_resp_data;
                end
                S_HOLD:  deliver = 1'b1;
                default: deliver = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            req_pc      <= '0;
            buf_instr   <= NOP_INSTR;
            IF_ID_PC    <= '0;
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_Valid <= 1'b0;
        end else if (IF_Flush) begin
            pc          <= branch_target;
            IF_ID_PC    <= pc;
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_Valid <= 1'b0;
            // A request already on the wire must have its response swallowed in S_DROP.
            case (state)
                S_REQ:   state <= req_fire ? S_DROP : S_REQ;
                S_WAIT:  state <= imem_resp_valid ? S_REQ : S_DROP;
                S_HOLD:  state <= S_REQ;
                S_DROP:  state <= imem_resp_valid ? S_REQ : S_DROP;
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        req_pc <= pc;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (advance) begin
                            state <= S_REQ;
                        end else begin
                            buf_instr <= imem_resp_data;
                            state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (advance) state <= S_REQ;
                end
                S_DROP: begin
                    if (imem_resp_valid) state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase

            if (deliver) begin
                pc          <= pc_next;
                IF_ID_PC    <= req_pc;
                IF_ID_Instr <= deliver_instr;
                IF_ID_Valid <= 1'b1;
            end else if (IF_ID_Write) begin
                IF_ID_PC    <= pc;
                IF_ID_Instr <= NOP_INSTR;
                IF_ID_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: the bench plays the instruction memory cycle by cycle
// and compares PC, request and IF/ID outputs against hand-computed values.
module tb_fetch_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        IF_Flush;
    logic [31:0] branch_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] pc_out;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] STALE = 32'hDEAD_BEEF;

    fetch_stage_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .PCWrite        (PCWrite),
        .IF_ID_Write    (IF_ID_Write),
        .IF_Flush       (IF_Flush),
        .branch_target  (branch_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .pc_out         (pc_out),
        .IF_ID_PC       (IF_ID_PC),
        .IF_ID_Instr    (IF_ID_Instr),
        .IF_ID_Valid    (IF_ID_Valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake();
        imem_resp_valid = 1'b0;
        tick();
    endtask

    task automatic respond(input logic [31:0] d);
        imem_resp_valid = 1'b1;
        imem_resp_data  = d;
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %0b exp 0", imem_req_valid); else n_pass++;
        n_total++; if (pc_out !== 32'h0) $display("FAIL rst_pc got %h exp 00000000", pc_out); else n_pass++;
        n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", IF_ID_Valid); else n_pass++;
        n_total++; if (IF_ID_Instr !== NOP) $display("FAIL rst_instr got %h exp %h", IF_ID_Instr, NOP); else n_pass++;
        n_total++; if (IF_ID_PC !== 32'h0) $display("FAIL rst_ifid_pc got %h exp 00000000", IF_ID_PC); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (imem_req_valid !== 1'b1) $display("FAIL post_rst_req_valid got %0b exp 1", imem_req_valid); else n_pass++;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            automatic logic [31:0] a = 32'(4 * i);
            n_total++; if (imem_req_valid !== 1'b1) $display("FAIL seq_req_valid[%0d] got %0b exp 1", i, imem_req_valid); else n_pass++;
            n_total++; if (imem_req_addr !== a) $display("FAIL seq_addr[%0d] got %h exp %h", i, imem_req_addr, a); else n_pass++;
            handshake();
            n_total++; if (imem_req_valid !== 1'b0) $display("FAIL seq_wait_req[%0d] got %0b exp 0", i, imem_req_valid); else n_pass++;
            n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL seq_bubble[%0d] got %0b exp 0", i, IF_ID_Valid); else n_pass++;
            respond(ins(a));
            n_total++; if (IF_ID_PC !== a) $display("FAIL seq_ifid_pc[%0d] got %h exp %h", i, IF_ID_PC, a); else n_pass++;
            n_total++; if (IF_ID_Instr !== ins(a)) $display("FAIL seq_instr[%0d] got %h exp %h", i, IF_ID_Instr, ins(a)); else n_pass++;
            n_total++; if (IF_ID_Valid !== 1'b1) $display("FAIL seq_valid[%0d] got %0b exp 1", i, IF_ID_Valid); else n_pass++;
            n_total++; if (pc_out !== a + 32'd4) $display("FAIL seq_pc[%0d] got %h exp %h", i, pc_out, a + 32'd4); else n_pass++;
        end
    endtask

    task automatic test_stall();
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        handshake();
        n_total++; if (IF_ID_PC !== 32'h8) $display("FAIL stall_hold_pc got %h exp 00000008", IF_ID_PC); else n_pass++;
        n_total++; if (IF_ID_Valid !== 1'b1) $display("FAIL stall_hold_valid got %0b exp 1", IF_ID_Valid); else n_pass++;
        respond(ins(32'hC));
        n_total++; if (IF_ID_PC !== 32'h8) $display("FAIL stall_hold2_pc got %h exp 00000008", IF_ID_PC); else n_pass++;
        n_total++; if (IF_ID_Instr !== ins(32'h8)) $display("FAIL stall_hold2_instr got %h exp %h", IF_ID_Instr, ins(32'h8)); else n_pass++;
        n_total++; if (pc_out !== 32'hC) $display("FAIL stall_pc got %h exp 0000000c", pc_out); else n_pass++;
        n_total++; if (imem_req_valid !== 1'b0) $display("FAIL stall_no_refetch got %0b exp 0", imem_req_valid); else n_pass++;
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        tick();
        n_total++; if (IF_ID_PC !== 32'hC) $display("FAIL stall_rel_pc got %h exp 0000000c", IF_ID_PC); else n_pass++;
        n_total++; if (IF_ID_Instr !== ins(32'hC)) $display("FAIL stall_rel_instr got %h exp %h", IF_ID_Instr, ins(32'hC)); else n_pass++;
        n_total++; if (IF_ID_Valid !== 1'b1) $display("FAIL stall_rel_valid got %0b exp 1", IF_ID_Valid); else n_pass++;
        n_total++; if (imem_req_addr !== 32'h10) $display("FAIL stall_next_addr got %h exp 00000010", imem_req_addr); else n_pass++;
    endtask

    task automatic test_flush_wait();
        handshake();
        IF_Flush      = 1'b1;
        branch_target = 32'h40;
        tick();
        IF_Flush = 1'b0;
        n_total++; if (pc_out !== 32'h40) $display("FAIL fw_pc got %h exp 00000040", pc_out); else n_pass++;
        n_total++; if (imem_req_valid !== 1'b0) $display("FAIL fw_drop_req got %0b exp 0", imem_req_valid); else n_pass++;
        n_total++; if (IF_ID_Instr !== NOP) $display("FAIL fw_instr got %h exp %h", IF_ID_Instr, NOP); else n_pass++;
        n_total++; if (IF_ID_PC !== 32'h10) $display("FAIL fw_ifid_pc got %h exp 00000010", IF_ID_PC); else n_pass++;
        tick();
        n_total++; if (imem_req_valid !== 1'b0) $display("FAIL fw_drop_req2 got %0b exp 0", imem_req_valid); else n_pass++;
        respond(STALE);
        n_total++; if (imem_req_valid !== 1'b1) $display("FAIL fw_req_valid got %0b exp 1", imem_req_valid); else n_pass++;
        n_total++; if (imem_req_addr !== 32'h40) $display("FAIL fw_addr got %h exp 00000040", imem_req_addr); else n_pass++;
        n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL fw_stale_valid got %0b exp 0", IF_ID_Valid); else n_pass++;
        n_total++; if (IF_ID_Instr !== NOP) $display("FAIL fw_stale_instr got %h exp %h", IF_ID_Instr, NOP); else n_pass++;
        handshake();
        respond(ins(32'h40));
        n_total++; if (IF_ID_PC !== 32'h40) $display("FAIL fw_new_pc got %h exp 00000040", IF_ID_PC); else n_pass++;
        n_total++; if (IF_ID_Valid !== 1'b1) $display("FAIL fw_new_valid got %0b exp 1", IF_ID_Valid); else n_pass++;
        n_total++; if (pc_out !== 32'h44) $display("FAIL fw_next_pc got %h exp 00000044", pc_out); else n_pass++;
    endtask

    task automatic test_flush_resp();
        handshake();
        IF_Flush        = 1'b1;
        branch_target   = 32'h102;
        imem_resp_valid = 1'b1;
        imem_resp_data  = STALE;
        tick();
        IF_Flush        = 1'b0;
        imem_resp_valid = 1'b0;
        n_total++; if (imem_req_valid !== 1'b1) $display("FAIL fr_req_valid got %0b exp 1", imem_req_valid); else n_pass++;
        n_total++; if (imem_req_addr !== 32'h102) $display("FAIL fr_addr got %h exp 00000102", imem_req_addr); else n_pass++;
        n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL fr_valid got %0b exp 0", IF_ID_Valid); else n_pass++;
        n_total++; if (IF_ID_Instr !== NOP) $display("FAIL fr_instr got %h exp %h", IF_ID_Instr, NOP); else n_pass++;
        n_total++; if (IF_ID_PC !== 32'h44) $display("FAIL fr_ifid_pc got %h exp 00000044", IF_ID_PC); else n_pass++;
        handshake();
        respond(ins(32'h102));
        n_total++; if (IF_ID_PC !== 32'h102) $display("FAIL fr_new_pc got %h exp 00000102", IF_ID_PC); else n_pass++;
        n_total++; if (pc_out !== 32'h106) $display("FAIL fr_next_pc got %h exp 00000106", pc_out); else n_pass++;
    endtask

    task automatic test_ready_low();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = STALE;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++; if (imem_req_valid !== 1'b1) $display("FAIL rl_req_valid[%0d] got %0b exp 1", i, imem_req_valid); else n_pass++;
            n_total++; if (imem_req_addr !== 32'h106) $display("FAIL rl_addr[%0d] got %h exp 00000106", i, imem_req_addr); else n_pass++;
            n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL rl_spurious[%0d] got %0b exp 0", i, IF_ID_Valid); else n_pass++;
        end
        imem_req_ready = 1'b1;
        handshake();
        respond(ins(32'h106));
        n_total++; if (IF_ID_Instr !== ins(32'h106)) $display("FAIL rl_instr got %h exp %h", IF_ID_Instr, ins(32'h106)); else n_pass++;
        n_total++; if (pc_out !== 32'h10A) $display("FAIL rl_next_pc got %h exp 0000010a", pc_out); else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        imem_req_ready = 1'b0;
        IF_Flush       = 1'b1;
        branch_target  = 32'hFFFF_FFFC;
        tick();
        IF_Flush       = 1'b0;
        imem_req_ready = 1'b1;
        n_total++; if (pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_start_pc got %h exp fffffffc", pc_out); else n_pass++;
        handshake();
        respond(ins(32'hFFFF_FFFC));
        n_total++; if (IF_ID_PC !== 32'hFFFF_FFFC) $display("FAIL wrap_ifid_pc got %h exp fffffffc", IF_ID_PC); else n_pass++;
        n_total++; if (pc_out !== 32'h0) $display("FAIL wrap_pc got %h exp 00000000", pc_out); else n_pass++;
        imem_req_ready = 1'b0;
        IF_Flush       = 1'b1;
        branch_target  = 32'h200;
        tick();
        IF_Flush       = 1'b0;
        imem_req_ready = 1'b1;
        handshake();
        n_total++; if (pc_out !== 32'h200) $display("FAIL mr_pc_before got %h exp 00000200", pc_out); else n_pass++;
        reset           = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = ins(32'h200);
        tick();
        imem_resp_valid = 1'b0;
        n_total++; if (pc_out !== 32'h0) $display("FAIL mr_pc got %h exp 00000000", pc_out); else n_pass++;
        n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL mr_valid got %0b exp 0", IF_ID_Valid); else n_pass++;
        n_total++; if (imem_req_valid !== 1'b0) $display("FAIL mr_req_valid got %0b exp 0", imem_req_valid); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (imem_req_addr !== 32'h0) $display("FAIL mr_addr got %h exp 00000000", imem_req_addr); else n_pass++;
        n_total++; if (imem_req_valid !== 1'b1) $display("FAIL mr_req_after got %0b exp 1", imem_req_valid); else n_pass++;
    endtask

    initial begin
        reset           = 1'b1;
        PCWrite         = 1'b1;
        IF_ID_Write     = 1'b1;
        IF_Flush        = 1'b0;
        branch_target   = '0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_flush_wait();
        test_flush_resp();
        test_ready_low();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
